// File: rtl/mvm_pkg.sv
// Shared types and width helpers for the matrix-vector multiplier.
package mvm_pkg;

    localparam int unsigned MvmM = 12;
    localparam int unsigned MvmP = 1;
    localparam int unsigned MvmB = 12;
    localparam int unsigned MvmG = 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadX,
        StCompute,
        StDrain,
        StOutput
    } mvm_state_e;

    function automatic int unsigned addr_w(input int unsigned m);
        return $clog2(m * m);
    endfunction

    function automatic int unsigned idx_w(input int unsigned m);
        return $clog2(m);
    endfunction

    function automatic int unsigned out_w(input int unsigned b);
        return 2 * b;
    endfunction

endpackage

// File: rtl/mvm_mac.sv
// One multiply-accumulate lane: signed BxB product, optional product register,
// 2B-bit wrapping accumulator restarted by first_i.
module mvm_mac
    import mvm_pkg::*;
#(
    parameter int unsigned B = MvmB,
    parameter int unsigned G = MvmG
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          vld_i,
    input  logic                          first_i,
    input  logic                          last_i,
    input  logic signed [B-1:0]           a_i,
    input  logic signed [B-1:0]           b_i,
    output logic signed [out_w(B)-1:0]    acc_o,
    output logic                          acc_vld_o
);

    localparam int unsigned W = out_w(B);

    logic signed [W-1:0] a_ext, b_ext, prod;
    logic signed [W-1:0] prod_s;
    logic                vld_s, first_s, last_s;
    logic signed [W-1:0] acc_q;
    logic                acc_vld_q;

    assign a_ext = {{B{a_i[B-1]}}, a_i};
    assign b_ext = {{B{b_i[B-1]}}, b_i};
    assign prod  = a_ext * b_ext;

    if (G != 0) begin : g_pipe
        logic signed [W-1:0] prod_q;
        logic                vld_q, first_q, last_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                prod_q  <= '0;
                vld_q   <= 1'b0;
                first_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                prod_q  <= prod;
                vld_q   <= vld_i;
                first_q <= first_i;
                last_q  <= last_i;
            end
        end

        assign prod_s  = prod_q;
        assign vld_s   = vld_q;
        assign first_s = first_q;
        assign last_s  = last_q;
    end else begin : g_comb
        assign prod_s  = prod;
        assign vld_s   = vld_i;
        assign first_s = first_i;
        assign last_s  = last_i;
    end

    // acc_vld_o marks the cycle in which acc_o holds a finished row sum.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q     <= '0;
            acc_vld_q <= 1'b0;
        end else begin
            if (vld_s) begin
                acc_q <= first_s ? prod_s : acc_q + prod_s;
            end
            acc_vld_q <= vld_s & last_s;
        end
    end

    assign acc_o     = acc_q;
    assign acc_vld_o = acc_vld_q;

endmodule

// File: rtl/mvm_12_1_12_1.sv
// Matrix-vector multiplier core: serial load of A and x, P-lane compute of y = A*x,
// one-cycle done pulse followed by M serial result words.
module mvm_12_1_12_1
    import mvm_pkg::*;
#(
    parameter int unsigned M = MvmM,
    parameter int unsigned P = MvmP,
    parameter int unsigned B = MvmB,
    parameter int unsigned G = MvmG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  loadMatrix,
    input  logic                  loadVector,
    input  logic                  start,
    output logic                  done,
    input  logic signed [B-1:0]   data_in,
    output logic signed [2*B-1:0] data_out
);

    localparam int unsigned AW     = addr_w(M);
    localparam int unsigned IW     = idx_w(M);
    localparam int unsigned OW     = out_w(B);
    localparam int unsigned Groups = M / P;

    mvm_state_e state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] k_q, k_d;
    logic [IW-1:0] g_q, g_d;
    logic [IW-1:0] wg_q, wg_d;
    logic [IW-1:0] out_q, out_d;
    logic          done_q, done_d;
    logic signed [OW-1:0] data_out_q, data_out_d;

    logic a_we, x_we, issue, y_we;

    logic signed [B-1:0]  a_mem [M*M];
    logic signed [B-1:0]  x_mem [M];
    logic signed [OW-1:0] y_mem [M];

    logic signed [B-1:0]  a_op   [P];
    logic signed [OW-1:0] acc    [P];
    logic [P-1:0]         acc_vld;

    // Operand storage is deliberately outside the reset domain so it survives reset.
    always_ff @(posedge clk) begin
        if (a_we) begin
            a_mem[cnt_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (x_we) begin
            x_mem[cnt_q[IW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (y_we) begin
            for (int unsigned l = 0; l < P; l++) begin
                y_mem[IW'(32'(wg_q) * P + l)] <= acc[l];
            end
        end
    end

    always_comb begin
        for (int unsigned l = 0; l < P; l++) begin
            a_op[l] = a_mem[AW'((32'(g_q) * P + l) * M + 32'(k_q))];
        end
    end

    for (genvar l = 0; l < P; l++) begin : g_lane
        mvm_mac #(
            .B(B),
            .G(G)
        ) u_mac (
            .clk_i    (clk),
            .rst_ni   (reset),
            .vld_i    (issue),
            .first_i  (k_q == '0),
            .last_i   (k_q == IW'(M - 1)),
            .a_i      (a_op[l]),
            .b_i      (x_mem[k_q]),
            .acc_o    (acc[l]),
            .acc_vld_o(acc_vld[l])
        );
    end

    // Lanes run in lockstep, so all finish a row group together.
    assign y_we = &acc_vld;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        g_d        = g_q;
        wg_d       = y_we ? wg_q + IW'(1) : wg_q;
        out_d      = out_q;
        done_d     = 1'b0;
        data_out_d = data_out_q;
        a_we       = 1'b0;
        x_we       = 1'b0;
        issue      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (loadMatrix) begin
                    state_d = StLoadA;
                    cnt_d   = '0;
                end else if (loadVector) begin
                    state_d = StLoadX;
                    cnt_d   = '0;
                end else if (start) begin
                    state_d = StCompute;
                    k_d     = '0;
                    g_d     = '0;
                    wg_d    = '0;
                end
            end
            StLoadA: begin
                a_we  = 1'b1;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(M * M - 1)) begin
                    state_d = StIdle;
                end
            end
            StLoadX: begin
                x_we  = 1'b1;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(M - 1)) begin
                    state_d = StIdle;
                end
            end
            StCompute: begin
                issue = 1'b1;
                if (k_q == IW'(M - 1)) begin
                    k_d = '0;
                    g_d = g_q + IW'(1);
                    if (g_q == IW'(Groups - 1)) begin
                        state_d = StDrain;
                    end
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            StDrain: begin
                if (y_we && wg_q == IW'(Groups - 1)) begin
                    done_d  = 1'b1;
                    out_d   = '0;
                    state_d = StOutput;
                end
            end
            StOutput: begin
                data_out_d = y_mem[out_q];
                out_d      = out_q + IW'(1);
                if (out_q == IW'(M - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            k_q        <= '0;
            g_q        <= '0;
            wg_q       <= '0;
            out_q      <= '0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            g_q        <= g_d;
            wg_q       <= wg_d;
            out_q      <= out_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
        end
    end

    assign done     = done_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_mvm_12_1_12_1.sv
// Self-checking bench for mvm_12_1_12_1: directed table, corner sequences, random regression.
module tb_mvm_12_1_12_1;

    localparam int M      = 12;
    localparam int B      = 12;
    localparam int MM     = M * M;
    localparam int LatMax = MM + 2 + 4;
    localparam int NOps   = 400;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  loadMatrix, loadVector, start;
    logic                  done;
    logic signed [B-1:0]   data_in;
    logic signed [2*B-1:0] data_out;

    always #5 clk = ~clk;

    mvm_12_1_12_1 dut (
        .clk       (clk),
        .reset     (reset),
        .loadMatrix(loadMatrix),
        .loadVector(loadVector),
        .start     (start),
        .done      (done),
        .data_in   (data_in),
        .data_out  (data_out)
    );

    int ref_A   [MM];
    int ref_x   [M];
    int stage_A [MM];
    int stage_x [M];
    logic signed [2*B-1:0] got_y [M];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string name;
        int    a_val;
        int    x_val;
        int    exp_y;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Golden row result: plain dot product reduced to a 24-bit signed word.
    function automatic longint model_y(input int j);
        longint s = 0;
        logic signed [2*B-1:0] w;
        for (int k = 0; k < M; k++) s += longint'(ref_A[j*M+k]) * longint'(ref_x[k]);
        w = s[2*B-1:0];
        return longint'(w);
    endfunction

    task automatic fill_stage(input int a, input int x);
        for (int n = 0; n < MM; n++) stage_A[n] = a;
        for (int k = 0; k < M; k++) stage_x[k] = x;
    endtask

    // Feeds `words` matrix words; fewer than MM aborts the load with a reset pulse.
    task automatic load_matrix(input int words);
        @(negedge clk); loadMatrix = 1'b1;
        @(negedge clk); loadMatrix = 1'b0;
        for (int n = 0; n < words; n++) begin
            data_in = B'(stage_A[n]);
            @(negedge clk);
            ref_A[n] = stage_A[n];
        end
        if (words < MM) begin
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
        end
    endtask

    task automatic load_vector();
        @(negedge clk); loadVector = 1'b1;
        @(negedge clk); loadVector = 1'b0;
        for (int k = 0; k < M; k++) begin
            data_in = B'(stage_x[k]);
            @(negedge clk);
            ref_x[k] = stage_x[k];
        end
    endtask

    task automatic run_compute(input bit poke);
        int  n;
        bit  seen;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("done_after_start", longint'(done), 0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < LatMax + 20) begin
            @(posedge clk); #1;
            n++;
            loadVector = (poke && n == 5);
            if (poke && n == 5) data_in = B'(99);
            seen = done;
        end
        loadVector = 1'b0;
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL done_timeout: no done within %0d cycles, required <= %0d", n, LatMax);
        end else if (n > LatMax) begin
            n_err++;
            $display("FAIL latency: done after %0d cycles, required <= %0d", n, LatMax);
        end
        for (int k = 0; k < M; k++) begin
            @(posedge clk); #1;
            got_y[k] = data_out;
            if (k == 0) chk("done_single_pulse", longint'(done), 0);
        end
    endtask

    task automatic check_const(input string name, input longint exp);
        for (int j = 0; j < M; j++) chk(name, longint'(got_y[j]), exp);
    endtask

    task automatic check_model(input string name);
        for (int j = 0; j < M; j++) chk(name, longint'(got_y[j]), model_y(j));
    endtask

    function automatic int rnd_val();
        return int'($urandom_range(0, 2808)) - 1404;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rst_op;
        int r;

        vecs[0] = '{"neg_extreme",  -63,   63, -47628};
        vecs[1] = '{"wrap_zero",  -2048, -2048,      0};
        vecs[2] = '{"wrap_pos",    2047, -2048,  24576};
        vecs[3] = '{"neg_ones",      -1,    -1,     12};
        vecs[4] = '{"range_edge",  1404, -1404, -6877376};

        reset      = 1'b0;
        loadMatrix = 1'b0;
        loadVector = 1'b0;
        start      = 1'b0;
        data_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_done", longint'(done), 0);
        chk("reset_data_out", longint'(data_out), 0);
        @(negedge clk); reset = 1'b1;

        // Identity matrix returns x unchanged
        for (int n = 0; n < MM; n++) stage_A[n] = (n / M == n % M) ? 1 : 0;
        for (int k = 0; k < M; k++) stage_x[k] = k + 1;
        load_matrix(MM);
        load_vector();
        run_compute(1'b0);
        for (int j = 0; j < M; j++) chk("identity_y", longint'(got_y[j]), j + 1);

        for (int i = 0; i < 5; i++) begin
            fill_stage(vecs[i].a_val, vecs[i].x_val);
            load_matrix(MM);
            load_vector();
            run_compute(1'b0);
            check_const(vecs[i].name, vecs[i].exp_y);
        end

        // Reload only x; A must be retained
        fill_stage(2, 3);
        load_matrix(MM);
        load_vector();
        run_compute(1'b0);
        check_const("reload_full", 72);
        fill_stage(2, -1);
        load_vector();
        run_compute(1'b0);
        check_const("reload_x_only", -24);

        // loadVector during compute is ignored
        fill_stage(2, 3);
        load_vector();
        run_compute(1'b1);
        check_const("ignored_cmd", 72);
        run_compute(1'b0);
        check_const("ignored_cmd_x_kept", 72);

        // Operands survive reset; outputs are cleared
        fill_stage(5, 7);
        load_matrix(MM);
        load_vector();
        run_compute(1'b0);
        check_const("pre_reset", 420);
        @(negedge clk); reset = 1'b0;
        #1;
        chk("reset_clears_data_out", longint'(data_out), 0);
        chk("reset_clears_done", longint'(done), 0);
        @(negedge clk); reset = 1'b1;
        run_compute(1'b0);
        check_const("reset_retention", 420);

        // Random regression against the golden model
        rst_op = int'($urandom_range(50, NOps - 50));
        for (int op = 0; op < NOps; op++) begin
            if (op == rst_op) begin
                for (int n = 0; n < MM; n++) stage_A[n] = rnd_val();
                load_matrix(int'($urandom_range(1, MM - 1)));
            end
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                for (int n = 0; n < MM; n++) stage_A[n] = rnd_val();
                load_matrix(MM);
            end else if (r < 5) begin
                for (int k = 0; k < M; k++) stage_x[k] = rnd_val();
                load_vector();
            end else begin
                run_compute(1'b0);
                check_model("random_y");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
